// File: rtl/output_port_scheduler.sv
// Packet-aware round-robin scheduler for one output port; registered output one cycle after pop.
// OUT_READY=0 freezes pops, grant and counters; a granted source starved for STALL_MAX ready cycles is aborted.
module output_port_scheduler #(
  parameter int LEN_WIDTH = 8,
  parameter int STALL_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [32:0] NOBLOCKOBUF_FROM_1,
  input  logic [32:0] NOBLOCKOBUF_FROM_2,
  input  logic [32:0] NOBLOCKOBUF_FROM_3,
  input  logic [32:0] NOBLOCKOBUF_FROM_4,
  output logic [3:0]  POP,
  input  logic        OUT_READY,
  output logic [31:0] OUTPUT_PORT,
  output logic        OUT_VALID,
  output logic [1:0]  GRANT,
  output logic        BUSY,
  output logic        STALL_ERR
);

  localparam int SCW = $clog2(STALL_MAX + 1);
  localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_rr_ptr;
  logic [1:0]           r_grant;
  logic                 r_busy;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [SCW-1:0]       r_stall_cnt;
  logic [31:0]          r_out_dat;
  logic                 r_out_vld;
  logic                 r_stall_err;

  logic [3:0]           w_vld;
  logic [31:0]          w_dat [4];
  logic                 w_found;
  logic [1:0]           w_pick;
  logic                 w_gnt_vld;
  logic [31:0]          w_gnt_dat;
  logic [LEN_WIDTH-1:0] w_hdr_len;
  logic                 w_active;
  logic                 w_pop;
  logic                 w_eop;
  logic                 w_stall;
  logic                 w_abort;

  assign w_vld    = {NOBLOCKOBUF_FROM_4[32], NOBLOCKOBUF_FROM_3[32],
                     NOBLOCKOBUF_FROM_2[32], NOBLOCKOBUF_FROM_1[32]};
  assign w_dat[0] = NOBLOCKOBUF_FROM_1[31:0];
  assign w_dat[1] = NOBLOCKOBUF_FROM_2[31:0];
  assign w_dat[2] = NOBLOCKOBUF_FROM_3[31:0];
  assign w_dat[3] = NOBLOCKOBUF_FROM_4[31:0];

  // Rotating scan: first valid buffer at or after rr_ptr, wrapping 3 -> 0.
  always_comb begin
    logic [1:0] idx;
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = r_rr_ptr + 2'(i);
      if (!w_found && w_vld[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  assign w_gnt_vld = w_vld[r_grant];
  assign w_gnt_dat = w_dat[r_grant];
  assign w_hdr_len = w_gnt_dat[LEN_WIDTH-1:0];
  assign w_active  = (r_state != S_IDLE);
  assign w_pop     = w_active && w_gnt_vld && OUT_READY;
  assign w_eop     = w_pop && (((r_state == S_HDR) && (w_hdr_len == '0)) ||
                               ((r_state == S_PAY) && (r_remaining == LEN_WIDTH'(1))));
  assign w_stall   = w_active && OUT_READY && !w_gnt_vld;
  assign w_abort   = w_stall && (r_stall_cnt == STALL_LAST);

  assign POP         = w_pop ? (4'b0001 << r_grant) : 4'b0000;
  assign OUTPUT_PORT = r_out_dat;
  assign OUT_VALID   = r_out_vld;
  assign GRANT       = r_grant;
  assign BUSY        = r_busy;
  assign STALL_ERR   = r_stall_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_HDR;
      S_HDR, S_PAY: begin
        if (w_eop || w_abort)                 w_state_nxt = S_IDLE;
        else if (w_pop && (r_state == S_HDR)) w_state_nxt = S_PAY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= 2'd0;
      r_grant     <= 2'd0;
      r_busy      <= 1'b0;
      r_remaining <= '0;
      r_stall_cnt <= '0;
      r_out_dat   <= 32'd0;
      r_out_vld   <= 1'b0;
      r_stall_err <= 1'b0;
    end else begin
      r_out_vld   <= w_pop;
      r_stall_err <= w_abort;
      if (w_pop) r_out_dat <= w_gnt_dat;

      if (r_state == S_IDLE) begin
        if (w_found) begin
          r_grant     <= w_pick;
          r_busy      <= 1'b1;
          r_stall_cnt <= '0;
        end
      end else if (w_pop) begin
        r_stall_cnt <= '0;
        r_remaining <= (r_state == S_HDR) ? w_hdr_len : (r_remaining - LEN_WIDTH'(1));
        if (w_eop) begin
          r_busy   <= 1'b0;
          r_rr_ptr <= r_grant + 2'd1;
        end
      end else if (w_abort) begin
        // Already-forwarded words stay forwarded; only the grant is released.
        r_busy      <= 1'b0;
        r_rr_ptr    <= r_grant + 2'd1;
        r_stall_cnt <= '0;
      end else if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + SCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: per-buffer word queues feed the DUT, and a packet-level
// reference model predicts every output each cycle.
module tb_output_port_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [32:0] NOBLOCKOBUF_FROM_1, NOBLOCKOBUF_FROM_2, NOBLOCKOBUF_FROM_3, NOBLOCKOBUF_FROM_4;
  logic [3:0]  POP;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUTPUT_PORT;
  logic        OUT_VALID;
  logic [1:0]  GRANT;
  logic        BUSY;
  logic        STALL_ERR;

  logic        in_vld [4];
  logic [31:0] in_dat [4];
  logic [31:0] q [4][$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_cyc = 0;
  int err_cyc = -1;

  // Reference model: packet ownership and word counts.
  bit          m_busy = 0;
  int          m_owner = 0;
  bit          m_hdr = 0;
  int          m_left = 0;
  int          m_stall = 0;
  int          m_ptr = 0;
  bit          m_ov = 0;
  logic [31:0] m_op = 32'd0;
  bit          m_err = 0;

  assign NOBLOCKOBUF_FROM_1 = {in_vld[0], in_dat[0]};
  assign NOBLOCKOBUF_FROM_2 = {in_vld[1], in_dat[1]};
  assign NOBLOCKOBUF_FROM_3 = {in_vld[2], in_dat[2]};
  assign NOBLOCKOBUF_FROM_4 = {in_vld[3], in_dat[3]};

  output_port_scheduler #(.LEN_WIDTH(8), .STALL_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .NOBLOCKOBUF_FROM_1(NOBLOCKOBUF_FROM_1), .NOBLOCKOBUF_FROM_2(NOBLOCKOBUF_FROM_2),
    .NOBLOCKOBUF_FROM_3(NOBLOCKOBUF_FROM_3), .NOBLOCKOBUF_FROM_4(NOBLOCKOBUF_FROM_4),
    .POP(POP), .OUT_READY(OUT_READY), .OUTPUT_PORT(OUTPUT_PORT), .OUT_VALID(OUT_VALID),
    .GRANT(GRANT), .BUSY(BUSY), .STALL_ERR(STALL_ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_hdr = 0; m_left = 0; m_stall = 0;
    m_ptr = 0; m_ov = 0; m_op = 32'd0; m_err = 0;
  endtask

  function automatic bit model_idle();
    return !m_busy && q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0;
  endfunction

  task automatic push_pkt(input int b, input int len, input logic [23:0] tag);
    q[b].push_back({tag, 8'(len)});
    for (int i = 0; i < len; i++) q[b].push_back($urandom);
  endtask

  // One cycle: drive at negedge, check just after, then advance the model past the posedge.
  task automatic step(input int rdy_pct, input int gap_pct);
    bit p;
    bit found;
    int o;
    @(negedge clk);
    OUT_READY = ($urandom_range(99) < rdy_pct);
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
        in_vld[i] = 1'b1;
        in_dat[i] = q[i][0];
      end else begin
        in_vld[i] = 1'b0;
        in_dat[i] = $urandom;
      end
    end
    p = m_busy && in_vld[m_owner] && OUT_READY;
    #1;
    chk("pop",       {28'd0, POP},          p ? (32'd1 << m_owner) : 32'd0);
    chk("out_valid", {31'd0, OUT_VALID},    {31'd0, m_ov});
    chk("out_data",  OUTPUT_PORT,           m_op);
    chk("grant",     {30'd0, GRANT},        32'(m_owner));
    chk("busy",      {31'd0, BUSY},         {31'd0, m_busy});
    chk("stall_err", {31'd0, STALL_ERR},    {31'd0, m_err});
    if (p) pop_cyc = cyc;
    if (STALL_ERR === 1'b1) err_cyc = cyc;

    m_ov  = p;
    m_err = 0;
    if (p) m_op = in_dat[m_owner];
    if (!m_busy) begin
      found = 0;
      for (int j = 0; j < 4; j++) begin
        o = (m_ptr + j) % 4;
        if (!found && in_vld[o]) begin
          found = 1; m_busy = 1; m_owner = o; m_hdr = 0; m_stall = 0;
        end
      end
    end else if (p) begin
      m_stall = 0;
      if (!m_hdr) begin
        m_left = int'(in_dat[m_owner] & 32'hFF);
        m_hdr  = 1;
      end else begin
        m_left--;
      end
      void'(q[m_owner].pop_front());
      if (m_left == 0) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 4;
      end
    end else if (OUT_READY) begin
      m_stall++;
      if (m_stall == 16) begin
        m_err = 1; m_busy = 0; m_stall = 0;
        m_ptr = (m_owner + 1) % 4;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && !model_idle(); k++) step(100, 0);
    chk("drain_done", {31'd0, model_idle()}, 32'd1);
    repeat (3) step(100, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      in_vld[i] = 1'b0;
      in_dat[i] = 32'd0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pop",   {28'd0, POP},       32'd0);
    chk("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_data",  OUTPUT_PORT,        32'd0);
    chk("rst_grant", {30'd0, GRANT},     32'd0);
    chk("rst_busy",  {31'd0, BUSY},      32'd0);
    chk("rst_err",   {31'd0, STALL_ERR}, 32'd0);
    rst = 1'b1;

    // Single-word packet on buffer 1.
    q[0].push_back(32'h0300_0500);
    drain();

    // Multi-word packet on buffer 2: header length 3, payloads 32, 10, 7.
    q[1].push_back(32'h0000_0003);
    q[1].push_back(32'd32);
    q[1].push_back(32'd10);
    q[1].push_back(32'd7);
    drain();

    // Round-robin: every buffer holds several single-word packets.
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < 4; b++) push_pkt(b, 0, 24'(16'hA000 + 16 * b + k));
    drain();

    // Backpressure for 5 cycles in the middle of a 3-payload packet.
    push_pkt(0, 3, 24'hB0B0B0);
    repeat (3) step(100, 0);
    repeat (5) step(0, 0);
    drain();

    // Stall abort: header announces 2 payloads that never arrive.
    q[0].push_back(32'h00C0_0002);
    step(100, 0);
    push_pkt(2, 1, 24'hD0D0D0);
    err_cyc = -1;
    for (int k = 0; k < 40 && err_cyc < 0; k++) step(100, 0);
    // The abort edge is 16 edges after the header-pop edge, so the pulse is seen 17 samples later.
    chk("stall_delay", 32'(err_cyc - pop_cyc), 32'd17);
    drain();

    // Asynchronous reset in the middle of a payload.
    push_pkt(1, 6, 24'hE0E0E0);
    repeat (4) step(100, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) in_vld[i] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_pop",   {28'd0, POP},       32'd0);
    chk("arst_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("arst_data",  OUTPUT_PORT,        32'd0);
    chk("arst_grant", {30'd0, GRANT},     32'd0);
    chk("arst_busy",  {31'd0, BUSY},      32'd0);
    chk("arst_err",   {31'd0, STALL_ERR}, 32'd0);
    model_reset();
    for (int i = 0; i < 4; i++) q[i].delete();
    @(negedge clk);
    rst = 1'b1;
    push_pkt(0, 1, 24'hF00001);
    push_pkt(3, 1, 24'hF00004);
    drain();

    // Randomized traffic with gaps and backpressure.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(9) == 0) begin
        int b;
        b = int'($urandom_range(3));
        if (q[b].size() < 16) push_pkt(b, int'($urandom_range(4)), 24'($urandom));
      end
      step(75, 10);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
